// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types: fetch states, opcodes, reset PC
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC select (sequential, taken branch, jump)
module fetch_next_pc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic [25:0]       instr,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_jump_target;

    assign w_pc4         = instr_pc + ADDR_W'(4);
    // Word offset, sign-extended then scaled to bytes; wraps modulo 2^ADDR_W.
    assign w_br_off      = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign w_jump_target = {w_pc4[ADDR_W-1:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = w_pc4;
        if (jump)
            next_pc = w_jump_target;
        else if (branch && zero)
            next_pc = w_pc4 + w_br_off;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetch front end
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [31:0]       retired_count
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req_valid;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [31:0]       r_retired;
    logic [ADDR_W-1:0] w_next_pc;

    fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .instr_pc (r_instr_pc),
        .instr    (r_instr[25:0]),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (w_next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= REQ;
            r_pc          <= PC_RESET;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_pc    <= PC_RESET;
            r_retired     <= 32'd0;
        end else begin
            case (r_state)
                // Coming out of reset the request is raised one edge late;
                // after a fire it is raised together with the new PC.
                REQ: begin
                    if (!r_req_valid)
                        r_req_valid <= 1'b1;
                    else if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        r_instr       <= imem_rsp_data;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_instr_valid && instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_pc          <= w_next_pc;
                        r_req_valid   <= 1'b1;
                        r_retired     <= r_retired + 32'd1;
                        r_state       <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign retired_count  = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;

    logic        req_valid, ivalid;
    logic [31:0] req_addr, instr, ipc, retired;
    logic        d2_req_valid, d2_ivalid;
    logic [31:0] d2_req_addr, d2_instr, d2_ipc, d2_retired;
    logic        d3_req_valid, d3_ivalid;
    logic [31:0] d3_req_addr, d3_instr, d3_ipc, d3_retired;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] exp_retired = 32'd0;

    localparam logic [31:0] BEQ_M4 = 32'h1000_FFFC;
    localparam logic [31:0] J_100  = 32'h0800_0100;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(ivalid), .instr(instr), .instr_pc(ipc), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .jump(jump), .retired_count(retired)
    );

    instr_fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(d2_req_valid), .imem_req_addr(d2_req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(d2_ivalid), .instr(d2_instr), .instr_pc(d2_ipc), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .jump(jump), .retired_count(d2_retired)
    );

    instr_fetch_unit #(.PC_RESET(32'h2000_0040)) dut3 (
        .clk(clk), .rst(rst),
        .imem_req_valid(d3_req_valid), .imem_req_addr(d3_req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(d3_ivalid), .instr(d3_instr), .instr_pc(d3_ipc), .instr_ready(instr_ready),
        .branch(branch), .zero(zero), .jump(jump), .retired_count(d3_retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_instr_valid", {31'd0, ivalid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", ipc, 32'h0);
        check("rst_retired", retired, 32'd0);
    endtask

    task automatic req_phase(input logic [31:0] a);
        check("req_valid", {31'd0, req_valid}, 32'd1);
        check("req_addr", req_addr, a);
        check("req_instr_valid", {31'd0, ivalid}, 32'd0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("wait_req_valid", {31'd0, req_valid}, 32'd0);
        check("wait_instr_valid", {31'd0, ivalid}, 32'd0);
    endtask

    task automatic rsp_phase(input logic [31:0] a, input logic [31:0] d);
        rsp_valid = 1'b1;
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
        check("hold_instr_valid", {31'd0, ivalid}, 32'd1);
        check("hold_instr", instr, d);
        check("hold_instr_pc", ipc, a);
    endtask

    task automatic serve(input logic [31:0] a, input logic [31:0] d);
        req_phase(a);
        rsp_phase(a, d);
    endtask

    task automatic consume(input logic b, input logic z, input logic j);
        branch = b;
        zero = z;
        jump = j;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch = 1'b0;
        zero = 1'b0;
        jump = 1'b0;
        exp_retired = exp_retired + 32'd1;
        check("fire_instr_valid", {31'd0, ivalid}, 32'd0);
        check("retired", retired, exp_retired);
    endtask

    initial begin
        tick();
        check_reset_values();
        check("rst_d2_addr", d2_req_addr, 32'hFFFF_FFFC);
        check("rst_d3_addr", d3_req_addr, 32'h2000_0040);
        rst = 1'b0;
        tick();

        // Sequential fetches with zero-wait memory
        serve(32'h0, 32'h2008_0001);
        consume(1'b0, 1'b0, 1'b0);
        check("d2_wrap_addr", d2_req_addr, 32'h0000_0000);
        check("d2_wrap_valid", {31'd0, d2_req_valid}, 32'd1);
        serve(32'h4, 32'h0000_0020);
        consume(1'b0, 1'b0, 1'b0);
        serve(32'h8, 32'h0000_0020);
        consume(1'b0, 1'b0, 1'b0);
        check("retired_three", retired, 32'd3);

        // Request stall with stray responses that must be ignored
        for (int i = 0; i < 4; i++) begin
            rsp_valid = 1'b1;
            rsp_data  = 32'hDEAD_BEEF;
            tick();
            check("stall_addr", req_addr, 32'hC);
            check("stall_valid", {31'd0, req_valid}, 32'd1);
            check("stall_ignore_rsp", {31'd0, ivalid}, 32'd0);
        end
        rsp_valid = 1'b0;
        serve(32'hC, 32'h0);
        consume(1'b0, 1'b0, 1'b0);

        // beq taken backwards
        serve(32'h10, BEQ_M4);
        consume(1'b1, 1'b1, 1'b0);
        check("beq_taken", req_addr, 32'h4);
        for (int a = 4; a < 16; a += 4) begin
            serve(32'(a), 32'h0);
            consume(1'b0, 1'b0, 1'b0);
        end

        // beq not taken, after a decode stall
        serve(32'h10, BEQ_M4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dstall_instr", instr, BEQ_M4);
            check("dstall_pc", ipc, 32'h10);
            check("dstall_valid", {31'd0, ivalid}, 32'd1);
            check("dstall_no_req", {31'd0, req_valid}, 32'd0);
            check("dstall_retired", retired, exp_retired);
        end
        consume(1'b1, 1'b0, 1'b0);
        check("beq_not_taken", req_addr, 32'h14);

        for (int a = 20; a < 48; a += 4) begin
            serve(32'(a), 32'h0);
            consume(1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset while waiting for a response at 0x30
        req_phase(32'h30);
        rst = 1'b1;
        #1;
        check_reset_values();
        rst = 1'b0;
        exp_retired = 32'd0;
        tick();
        check("post_rst_addr", req_addr, 32'h0);
        check("post_rst_valid", {31'd0, req_valid}, 32'd1);

        // Jump alone
        check("d3_start_addr", d3_req_addr, 32'h2000_0040);
        serve(32'h0, J_100);
        consume(1'b0, 1'b0, 1'b1);
        check("jump_addr", req_addr, 32'h0000_0400);
        check("d3_jump_addr", d3_req_addr, 32'h2000_0400);

        // Jump wins over a taken branch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_retired = 32'd0;
        tick();
        serve(32'h0, J_100);
        consume(1'b1, 1'b1, 1'b1);
        check("jump_prio_addr", req_addr, 32'h0000_0400);
        check("d3_jump_prio_addr", d3_req_addr, 32'h2000_0400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the MIPS core. Owns the PC and fetches instruction words from instruction memory over a valid/ready request channel and a valid response channel.
- Presents one instruction at a time to the decode stage. Decode splits out opcode [31:26] for the main control decoder.
- Consumes the decoder's branch/jump outputs and the ALU zero flag to select the next PC.
- At most one memory request outstanding; strictly in-order.

Parameters:
- PC_RESET, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC and address width.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, asynchronous active-high reset.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_addr, output, ADDR_W, word-aligned fetch address.
- imem_req_ready, input, 1, memory accepts request.
- imem_rsp_valid, input, 1, response data valid.
- imem_rsp_data, input, 32, fetched instruction word.
- instr_valid, output, 1, instr/instr_pc valid to decode.
- instr, output, 32, held instruction word.
- instr_pc, output, ADDR_W, PC of held instruction.
- instr_ready, input, 1, decode/execute consumes instruction this cycle.
- branch, input, 1, decoder branch signal for held instr.
- zero, input, 1, ALU zero flag for held instr.
- jump, input, 1, decoder jump signal for held instr.
- retired_count, output, 32, count of consumed instructions.

Behaviour:
- Reset values: state=REQ, pc=PC_RESET, imem_req_valid=0, imem_req_addr=PC_RESET, instr_valid=0, instr=0, instr_pc=PC_RESET, retired_count=0.
- State REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Move to WAIT when imem_req_ready=1.
  - Address stays stable while ready=0.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1, latch instr<=imem_rsp_data and instr_pc<=pc, then move to HOLD.
- State HOLD:
  - instr_valid=1; instr and instr_pc stay stable until fire.
  - fire = instr_valid & instr_ready.
  - On fire: pc<=next_pc, retired_count+=1, move to REQ.
- imem_rsp_valid outside WAIT is ignored.
- Minimum cost is 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait-state memory and instr_ready held high.
- next_pc is sampled only in the fire cycle (branch/zero/jump are combinational from instr):
  - pc4 = instr_pc + 4.
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - else branch & zero: pc4 + (sign-extended instr[15:0] << 2).
  - else: pc4.
- jump takes priority over branch when both are asserted.
- All PC arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0x0000_0000. Negative offsets wrap the same way.
- next_pc[1:0] is always 0.
- retired_count wraps from 0xFFFF_FFFF to 0.
- Reset asserted in any state:
  - Immediately forces the reset values and abandons any in-flight request.
  - Instruction memory shares rst, so no stale response can arrive.
- The first request is issued on the first clk edge after rst deasserts (state is already REQ).

Decomposition:
- Shared package mips_pkg:
  - fetch state enum {REQ, WAIT, HOLD}, 2-bit encoding.
  - opcode constants shared with the main control decoder: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010, OP_LUI=6'b001111, OP_ORI=6'b001101, OP_ADDI=6'b001000.
  - PC_RESET default.
- One sub-module, fetch_next_pc: purely combinational; inputs instr_pc, instr, branch, zero, jump; output next_pc. Unit-testable alone.

Test Plan:
- Reset release, memory ready=1, 1-cycle response:
  - imem_req_addr sequence 0x0, 0x4, 0x8.
  - instr_valid pulses every 3rd cycle.
  - retired_count reaches 3.
- beq at 0x10, instr[15:0]=0xFFFC, branch=1, zero=1 -> next imem_req_addr 0x04. Same instruction with zero=0 -> 0x14.
- j at 0x2000_0040, instr[25:0]=0x0000100 -> next address 0x2000_0400. With branch=1, zero=1 also asserted, jump still wins.
- Stalls:
  - imem_req_ready=0 for 4 cycles -> addr held stable.
  - instr_ready=0 for 5 cycles -> instr/instr_pc stable, no new request, retired_count unchanged.
- rst asserted mid-WAIT at pc=0x30 -> outputs return to reset values asynchronously; next request is to 0x0.
- PC_RESET=0xFFFF_FFFC, non-branch instruction consumed -> next request 0x0000_0000.
